// File: rtl/neuron_result_writer.sv
// Result writer: optional ReLU, small FIFO, and a req/ack drain to result memory at
// sequential addresses; pulses done once a layer has been fully written.
module neuron_result_writer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 8,
    parameter int RELU   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       num_outputs,
    input  logic              neuron_valid,
    input  logic [DATA_W-1:0] neuron_data,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_ack,
    output logic              full,
    output logic              busy,
    output logic              overflow,
    output logic              done
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   base_q;
    logic [15:0]         num_q;
    logic [15:0]         in_cnt;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W:0]      count;
    logic [ADDR_W-1:0]   fifo_addr [DEPTH];
    logic [DATA_W-1:0]   fifo_data [DEPTH];

    logic                fifo_empty;
    logic                fifo_full;
    logic                push;
    logic                pop;
    logic [DATA_W-1:0]   act_data;
    logic [ADDR_W-1:0]   push_addr;

    always_comb begin
        fifo_empty = (count == '0);
        fifo_full  = (count == (PTR_W+1)'(DEPTH));
        // full is judged on the registered occupancy, so a same-cycle pop cannot rescue a push
        push       = (state == RUN) && neuron_valid && !fifo_full;
        pop        = ((state == RUN) || (state == DRAIN)) && !fifo_empty && wr_ack;
        act_data   = ((RELU != 0) && neuron_data[DATA_W-1]) ? '0 : neuron_data;
        push_addr  = base_q + ADDR_W'(in_cnt);
    end

    assign wr_req  = !fifo_empty;
    assign wr_addr = fifo_empty ? '0 : fifo_addr[rd_ptr];
    assign wr_data = fifo_empty ? '0 : fifo_data[rd_ptr];
    assign full    = fifo_full;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= push_addr;
            fifo_data[wr_ptr] <= act_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            base_q   <= '0;
            num_q    <= '0;
            in_cnt   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;

            case (state)
                IDLE: begin
                    if (start) begin
                        base_q   <= base_addr;
                        num_q    <= num_outputs;
                        in_cnt   <= '0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                        if (num_outputs == '0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (neuron_valid) begin
                        // dropped values still consume a slot so later addresses stay aligned
                        if (fifo_full) overflow <= 1'b1;
                        in_cnt <= in_cnt + 16'd1;
                        if (in_cnt + 16'd1 == num_q) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fifo_empty) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_result_writer.sv
// Bench for neuron_result_writer: a RELU=1 and a RELU=0 instance share stimulus and are
// compared every cycle against a queue-based model, plus literal checks from the test plan.
module tb_neuron_result_writer;

    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, start, neuron_valid, wr_ack;
    logic [AW-1:0] base_addr;
    logic [15:0]   num_outputs;
    logic [DW-1:0] neuron_data;

    logic          a_req, a_full, a_busy, a_ovf, a_done;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_data;
    logic          b_req, b_full, b_busy, b_ovf, b_done;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_data;

    neuron_result_writer #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RELU(1)) dut_a (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .num_outputs(num_outputs), .neuron_valid(neuron_valid), .neuron_data(neuron_data),
        .wr_req(a_req), .wr_addr(a_addr), .wr_data(a_data), .wr_ack(wr_ack),
        .full(a_full), .busy(a_busy), .overflow(a_ovf), .done(a_done)
    );

    neuron_result_writer #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RELU(0)) dut_b (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .num_outputs(num_outputs), .neuron_valid(neuron_valid), .neuron_data(neuron_data),
        .wr_req(b_req), .wr_addr(b_addr), .wr_data(b_data), .wr_ack(wr_ack),
        .full(b_full), .busy(b_busy), .overflow(b_ovf), .done(b_done)
    );

    int total = 0;
    int bad   = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [DW-1:0] act_fn(bit relu, logic [DW-1:0] x);
        return (relu && x[DW-1]) ? '0 : x;
    endfunction

    // Behavioural model: a queue of pending writes plus layer bookkeeping.
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          mq[$];
    logic          m_busy, m_fin, m_ovf;
    logic [15:0]   m_in, m_num;
    logic [AW-1:0] m_base;

    always @(posedge clk) begin
        int   n;
        ent_t e;
        if (!reset) begin
            mq.delete();
            m_busy = 1'b0; m_fin = 1'b0; m_ovf = 1'b0;
            m_in = '0; m_num = '0; m_base = '0;
        end else if (m_fin) begin
            m_fin  = 1'b0;
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (start) begin
                m_base = base_addr; m_num = num_outputs; m_in = '0; m_ovf = 1'b0;
                m_busy = 1'b1;
                m_fin  = (num_outputs == 16'd0);
            end
        end else if (m_in == m_num && mq.size() == 0) begin
            m_fin = 1'b1;
        end else begin
            n = mq.size();
            if (n > 0 && wr_ack) void'(mq.pop_front());
            if (neuron_valid && m_in != m_num) begin
                if (n < DEPTH) begin
                    e.addr = m_base + m_in;
                    e.data = neuron_data;
                    mq.push_back(e);
                end else begin
                    m_ovf = 1'b1;
                end
                m_in = m_in + 16'd1;
            end
        end
    end

    bit          chk_en = 1'b0;
    logic [31:0] alog[$];
    logic [31:0] blog[$];
    int          a_done_cnt = 0;

    always @(negedge clk) begin
        logic          e_req;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_da, e_db;
        if (chk_en) begin
            e_req = (mq.size() != 0);
            e_addr = '0; e_da = '0; e_db = '0;
            if (e_req) begin
                e_addr = mq[0].addr;
                e_da   = act_fn(1'b1, mq[0].data);
                e_db   = act_fn(1'b0, mq[0].data);
            end
            check("a.wr_req",   32'(a_req),  32'(e_req));
            check("a.wr_addr",  32'(a_addr), 32'(e_addr));
            check("a.wr_data",  32'(a_data), 32'(e_da));
            check("a.full",     32'(a_full), 32'(mq.size() == DEPTH));
            check("a.busy",     32'(a_busy), 32'(m_busy));
            check("a.overflow", 32'(a_ovf),  32'(m_ovf));
            check("a.done",     32'(a_done), 32'(m_fin));
            check("b.wr_req",   32'(b_req),  32'(e_req));
            check("b.wr_addr",  32'(b_addr), 32'(e_addr));
            check("b.wr_data",  32'(b_data), 32'(e_db));
            check("b.overflow", 32'(b_ovf),  32'(m_ovf));
            check("b.done",     32'(b_done), 32'(m_fin));
            if (a_req && wr_ack) alog.push_back({a_addr, a_data});
            if (b_req && wr_ack) blog.push_back({b_addr, b_data});
            if (a_done) a_done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_layer(input logic [AW-1:0] b, input logic [15:0] n);
        base_addr = b; num_outputs = n; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int i;
        for (i = 0; i < budget && !a_done; i++) tick();
        check(name, 32'(a_done), 32'd1);
        tick();
    endtask

    task automatic clear_logs();
        alog.delete(); blog.delete(); a_done_cnt = 0;
    endtask

    initial begin
        logic [DW-1:0] v1 [4];
        logic [31:0]   w1 [4];
        reset = 1'b0; start = 1'b0; neuron_valid = 1'b0; wr_ack = 1'b0;
        base_addr = '0; num_outputs = '0; neuron_data = '0;
        tick(); tick();
        chk_en = 1'b1;
        check("reset busy", 32'(a_busy), 32'd0);
        check("reset wr_req", 32'(a_req), 32'd0);
        check("reset done", 32'(a_done), 32'd0);
        reset = 1'b1;
        tick();

        // basic layer
        clear_logs();
        v1 = '{16'h0005, 16'hFFF0, 16'h7FFF, 16'h8000};
        w1 = '{32'h0100_0005, 32'h0101_0000, 32'h0102_7FFF, 32'h0103_0000};
        wr_ack = 1'b1;
        start_layer(16'h0100, 16'd4);
        for (int i = 0; i < 4; i++) begin
            neuron_valid = 1'b1; neuron_data = v1[i];
            tick();
        end
        neuron_valid = 1'b0;
        wait_done("basic done", 20);
        check("basic busy after", 32'(a_busy), 32'd0);
        check("basic nwrites", alog.size(), 32'd4);
        for (int i = 0; i < 4 && i < alog.size(); i++) check("basic write", alog[i], w1[i]);
        check("basic done count", a_done_cnt, 32'd1);

        // backpressure
        clear_logs();
        wr_ack = 1'b0;
        start_layer(16'h2000, 16'd10);
        for (int i = 0; i < 10; i++) begin
            neuron_valid = 1'b1; neuron_data = DW'($urandom);
            tick();
            if (i == 7) check("bp full at 8", 32'(a_full), 32'd1);
        end
        neuron_valid = 1'b0;
        check("bp overflow", 32'(a_ovf), 32'd1);
        check("bp still full", 32'(a_full), 32'd1);
        wr_ack = 1'b1;
        wait_done("bp done", 40);
        check("bp nwrites", alog.size(), 32'd8);
        for (int i = 0; i < 8 && i < alog.size(); i++)
            check("bp addr", 32'(alog[i][31:16]), 32'h2000 + 32'(i));
        start_layer(16'h3000, 16'd1);
        check("bp overflow cleared", 32'(a_ovf), 32'd0);
        neuron_valid = 1'b1; neuron_data = 16'h0042;
        tick();
        neuron_valid = 1'b0;
        wait_done("bp2 done", 20);

        // stall stability, ack pattern 0,0,1
        clear_logs();
        wr_ack = 1'b0;
        start_layer(16'h1230, 16'd5);
        for (int k = 0; k < 200 && !a_done; k++) begin
            neuron_valid = (k < 5);
            neuron_data  = DW'($urandom);
            wr_ack       = (k % 3 == 2);
            tick();
        end
        neuron_valid = 1'b0;
        wait_done("stall done", 5);
        check("stall nwrites", alog.size(), 32'd5);
        for (int i = 0; i < 5 && i < alog.size(); i++)
            check("stall addr", 32'(alog[i][31:16]), 32'h1230 + 32'(i));
        check("stall done count", a_done_cnt, 32'd1);

        // zero-length layer with valids present
        clear_logs();
        wr_ack = 1'b1; neuron_valid = 1'b1;
        start_layer(16'h4000, 16'd0);
        check("zero done next cycle", 32'(a_done), 32'd1);
        tick();
        check("zero idle", 32'(a_busy), 32'd0);
        tick();
        neuron_valid = 1'b0;
        check("zero nwrites", alog.size(), 32'd0);

        // reset mid-layer
        clear_logs();
        wr_ack = 1'b0;
        start_layer(16'h5000, 16'd6);
        for (int i = 0; i < 3; i++) begin
            neuron_valid = 1'b1; neuron_data = 16'h0010 + DW'(i);
            tick();
        end
        neuron_valid = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("rst wr_req", 32'(a_req), 32'd0);
        check("rst busy", 32'(a_busy), 32'd0);
        check("rst full", 32'(a_full), 32'd0);
        check("rst wr_addr", 32'(a_addr), 32'd0);
        wr_ack = 1'b1;
        repeat (5) tick();
        check("rst no writes", alog.size(), 32'd0);
        start_layer(16'h5100, 16'd2);
        for (int i = 0; i < 2; i++) begin
            neuron_valid = 1'b1; neuron_data = 16'h0020 + DW'(i);
            tick();
        end
        neuron_valid = 1'b0;
        wait_done("rst relayer done", 20);
        check("rst relayer nwrites", alog.size(), 32'd2);
        if (alog.size() > 0) check("rst relayer addr", 32'(alog[0][31:16]), 32'h5100);

        // address wrap, RELU on vs off
        clear_logs();
        wr_ack = 1'b1;
        start_layer(16'hFFFF, 16'd2);
        neuron_valid = 1'b1; neuron_data = 16'h8001; tick();
        neuron_valid = 1'b1; neuron_data = 16'h0002; tick();
        neuron_valid = 1'b0;
        wait_done("wrap done", 20);
        check("wrap nwrites", blog.size(), 32'd2);
        if (blog.size() == 2) begin
            check("wrap b write0", blog[0], 32'hFFFF_8001);
            check("wrap b write1", blog[1], 32'h0000_0002);
        end
        if (alog.size() > 0) check("wrap a write0", alog[0], 32'hFFFF_0000);

        // randomized layers
        for (int l = 0; l < 25; l++) begin
            int  pv, pa, rst_at;
            bit  rst_hit;
            pv = $urandom_range(20, 100);
            pa = $urandom_range(10, 100);
            rst_at = ($urandom % 6 == 0) ? int'($urandom_range(1, 15)) : -1;
            rst_hit = 1'b0;
            for (int k = 0; k < 2; k++) begin
                neuron_valid = $urandom % 2; neuron_data = DW'($urandom); wr_ack = $urandom % 2;
                tick();
            end
            neuron_valid = 1'b0;
            start_layer(AW'($urandom), 16'($urandom_range(0, 20)));
            for (int c = 0; c < 800 && !a_done; c++) begin
                neuron_valid = ($urandom % 100) < pv;
                neuron_data  = DW'($urandom);
                wr_ack       = ($urandom % 100) < pa;
                start        = ($urandom % 16) == 0;
                base_addr    = AW'($urandom);
                num_outputs  = 16'($urandom_range(0, 20));
                tick();
                if (c == rst_at) begin
                    start = 1'b0; reset = 1'b0;
                    tick();
                    reset = 1'b1;
                    rst_hit = 1'b1;
                    break;
                end
            end
            start = 1'b0; neuron_valid = 1'b0;
            if (!rst_hit) check("random layer done", 32'(a_done), 32'd1);
            tick();
            tick();
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
